// File: rtl/alu_pkg.sv
// Shared types for the pipelined Y86 ALU: op and condition encodings, the
// condition-code layout and the branch/cmov condition evaluator.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_AND  = 3'd2,
    OP_XOR  = 3'd3,
    OP_SHL  = 3'd4,
    OP_SAR  = 3'd5,
    OP_ILL6 = 3'd6,
    OP_ILL7 = 3'd7
  } alu_op_e;

  typedef enum logic [2:0] {
    CND_ALWAYS = 3'd0,
    CND_LE     = 3'd1,
    CND_L      = 3'd2,
    CND_E      = 3'd3,
    CND_NE     = 3'd4,
    CND_GE     = 3'd5,
    CND_G      = 3'd6,
    CND_NEVER  = 3'd7
  } cnd_fn_e;

  typedef struct packed {
    logic zf;
    logic sf;
    logic of;
  } cc_t;

  localparam cc_t CC_RESET = 3'b100;

  function automatic logic cnd_eval(input cc_t cc, input cnd_fn_e fn);
    logic lt;
    lt = cc.sf ^ cc.of;
    case (fn)
      CND_ALWAYS: return 1'b1;
      CND_LE:     return lt | cc.zf;
      CND_L:      return lt;
      CND_E:      return cc.zf;
      CND_NE:     return !cc.zf;
      CND_GE:     return !lt;
      CND_G:      return !lt && !cc.zf;
      default:    return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: result, signed overflow and illegal-op flag
// for one operation.
module alu_core
  import alu_pkg::*;
#(
  parameter int W   = 64,
  parameter int SHW = $clog2(W)
) (
  input  alu_op_e        op,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [W-1:0]   res,
  output logic           ovf,
  output logic           err
);

  logic [SHW-1:0] sh_amt;
  assign sh_amt = b[SHW-1:0];

  always_comb begin
    // NOTE: every output gets a default before the case so no path infers a latch.
    res = '0;
    ovf = 1'b0;
    err = 1'b0;
    case (op)
      OP_ADD: begin
        res = a + b;
        ovf = (a[W-1] == b[W-1]) && (res[W-1] != a[W-1]);
      end
      OP_SUB: begin
        res = a - b;
        ovf = (a[W-1] != b[W-1]) && (res[W-1] != a[W-1]);
      end
      OP_AND: res = a & b;
      OP_XOR: res = a ^ b;
      OP_SHL: res = a << sh_amt;
      OP_SAR: res = $signed(a) >>> sh_amt;
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_pipe.sv
// Registered EXECUTE-stage ALU with a one-slot valid/ready output register,
// the Y86 condition-code register and the combinational branch condition.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int W   = 64,
  parameter int SHW = $clog2(W)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2:0]     in_op,
  input  logic [W-1:0]   in_a,
  input  logic [W-1:0]   in_b,
  input  logic           in_set_cc,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   out_result,
  output logic           out_ovf,
  output logic           out_err,
  output logic [2:0]     cc,
  input  logic [2:0]     cnd_fn,
  output logic           cnd
);

  logic         out_valid_q, out_valid_d;
  logic [W-1:0] out_result_q, out_result_d;
  logic         out_ovf_q, out_ovf_d;
  logic         out_err_q, out_err_d;
  cc_t          cc_q, cc_d;

  logic [W-1:0] core_res;
  logic         core_ovf;
  logic         core_err;
  logic         accept;

  alu_core #(.W(W), .SHW(SHW)) u_core (
    .op  (alu_op_e'(in_op)),
    .a   (in_a),
    .b   (in_b),
    .res (core_res),
    .ovf (core_ovf),
    .err (core_err)
  );

  // Single output slot: a pop and a push may share one edge.
  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_ovf_d    = out_ovf_q;
    out_err_d    = out_err_q;
    cc_d         = cc_q;
    if (accept) begin
      out_valid_d  = 1'b1;
      out_result_d = core_res;
      out_ovf_d    = core_ovf;
      out_err_d    = core_err;
      if (in_set_cc && !core_err) begin
        cc_d.zf = (core_res == '0);
        cc_d.sf = core_res[W-1];
        cc_d.of = core_ovf;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state uses non-blocking assignments so all flops update together.
    if (!rst_n) begin
      // NOTE: the data registers are reset too, so a discarded result never leaks out.
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_ovf_q    <= 1'b0;
      out_err_q    <= 1'b0;
      cc_q         <= CC_RESET;
    end else begin
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_ovf_q    <= out_ovf_d;
      out_err_q    <= out_err_d;
      cc_q         <= cc_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_ovf    = out_ovf_q;
  assign out_err    = out_err_q;
  assign cc         = cc_q;
  assign cnd        = cnd_eval(cc_q, cnd_fn_e'(cnd_fn));

endmodule

// File: doc/alu_pipe.md
# alu_pipe

Parametrised, registered successor to the combinational Y86 ALU, with a valid/ready handshake. It runs ADD, SUB, AND and XOR on `W`-bit operands and adds two shift operations. It holds the Y86 condition-code register (ZF, SF, OF) and evaluates branch/cmov conditions from that register. It sits in the EXECUTE stage between decode operand registers and the memory stage; one operation issues per cycle when not stalled.

## Interface
Parameters:
- `W`, 64: operand/result width; must be ≥ 8 and a power of two.
- `SHW`, $clog2(W): shift-amount width, derived; not overridden.

Ports:
- `clk` in 1: single clock; all state updates on rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `in_valid` in 1: operation presented.
- `in_ready` out 1: block can accept this cycle.
- `in_op` in 3: 0 ADD, 1 SUB, 2 AND, 3 XOR, 4 SHL, 5 SAR, 6–7 illegal.
- `in_a` in W: operand A, signed.
- `in_b` in W: operand B, signed.
- `in_set_cc` in 1: update CC from this operation.
- `out_valid` out 1: result register holds a pending result.
- `out_ready` in 1: downstream accepts the result.
- `out_result` out W: registered result.
- `out_ovf` out 1: registered signed overflow of the result.
- `out_err` out 1: registered illegal-op flag.
- `cc` out 3: {ZF, SF, OF} architectural condition codes.
- `cnd_fn` in 3: Y86 ifun: 0 always, 1 le, 2 l, 3 e, 4 ne, 5 ge, 6 g, 7 never.
- `cnd` out 1: combinational condition result from current `cc`.

## Operation
- Accept: `in_valid && in_ready`. `in_ready = !out_valid || out_ready`, so there is one output slot and no skid buffer.
- ADD: `a+b` modulo 2^W. OF is set when sign(a)==sign(b) and sign(res)!=sign(a).
- SUB: `a-b` modulo 2^W. OF is set when sign(a)!=sign(b) and sign(res)!=sign(a).
- AND and XOR: bitwise; OF=0.
- SHL: `a << b[SHW-1:0]`. SAR: arithmetic `a >>> b[SHW-1:0]`. Upper bits of b are ignored. OF=0.
- Illegal op (6, 7): result 0, OF=0, `out_err`=1.
  - CC is never updated for an illegal op, even when `in_set_cc`=1.
- CC update happens on the accept edge when `in_set_cc`=1 and the op is legal:
  - ZF = (res==0).
  - SF = res[W-1].
  - OF = computed overflow.
  - The new CC is visible in the same cycle `out_valid` rises.
- Without an accept, CC holds its value.
- `cnd`, with Z=ZF, S=SF, O=OF:
  - always → 1
  - le → (S^O)|Z
  - l → S^O
  - e → Z
  - ne → !Z
  - ge → !(S^O)
  - g → !(S^O)&!Z
  - never → 0
- `out_*` update only on accept. They hold stable while `out_valid && !out_ready`.
- Data path: the result is computed combinationally from the inputs and registered on accept. No multi-cycle operations.

## Timing
- Latency 1: an op accepted at edge N is presented with `out_valid`=1 after edge N.
- Throughput 1/cycle when `out_ready`=1 continuously.
- `out_valid` next state:
  - 1 on accept.
  - Else 0 when `out_ready`=1.
  - Else hold.
- Simultaneous pop and push (`out_valid && out_ready && in_valid`): the new result replaces the old one in the same edge; `out_valid` stays 1.
- Stall: with `out_valid`=1 and `out_ready`=0, `in_ready`=0. No accept occurs, so CC and the result are frozen.
- Reset, evaluated at the edge while `rst_n`=0:
  - `out_valid`=0, `out_result`=0, `out_ovf`=0, `out_err`=0.
  - `cc`=3'b100 (ZF=1, SF=0, OF=0).
  - `in_ready`=1 in the first cycle after reset.
  - A pending result is discarded when reset is asserted mid-operation.
- `cnd` is purely combinational from `cc` and `cnd_fn`; it reflects the CC after the last accepting edge.

## Structure
- Package `alu_pkg`:
  - `alu_op_e` (3-bit enum of the six ops plus ILLEGAL range).
  - `cnd_fn_e` (3-bit Y86 condition enum).
  - `cc_t` packed struct {zf, sf, of}.
  - Constant `CC_RESET = 3'b100`.
- Sub-module `alu_core #(W)`: combinational. It takes op, a and b and produces res, ovf and err.
- `alu_pipe` holds the handshake, the output register, the CC register and the `cnd` logic.

## Test plan
- Reset:
  - Stimulus: `rst_n`=0 for 2 cycles with `in_valid`=1, op=ADD, a=5, b=7.
  - Required: `out_valid`=0, `cc`=3'b100, `in_ready`=1 after release, no result emitted.
- ADD overflow (W=64):
  - Stimulus: a=0x7FFF_FFFF_FFFF_FFFF, b=1, `in_set_cc`=1.
  - Required: one cycle later result=0x8000_0000_0000_0000, `out_ovf`=1, cc={0,1,1}; `cnd_fn`=2 (l) gives `cnd`=0 and `cnd_fn`=1 (le) gives 0.
- SUB zero without CC update:
  - Stimulus: first SUB a=9, b=9 with `in_set_cc`=1, then XOR a=1, b=2 with `in_set_cc`=0.
  - Required: first result 0 with cc={1,0,0}; second result 3 with cc unchanged at {1,0,0}; `cnd_fn`=3 (e) gives `cnd`=1.
- Shifts:
  - Stimulus: SAR a=0x8000_0000_0000_0000, b=0x43 (low bits 3); then SHL a=1, b=63.
  - Required: first result 0xF000_0000_0000_0000; second result 0x8000_0000_0000_0000; OF=0 for both.
- Backpressure:
  - Stimulus: issue 3 ADDs back-to-back while `out_ready`=0 for 4 cycles, then 1.
  - Required: `in_ready`=0 after the first accept. The first result holds stable through the stall. The results drain in order, one per cycle, each matching its reference sum.
- Illegal op:
  - Stimulus: op=7, `in_set_cc`=1, from cc={0,1,0}.
  - Required: result 0, `out_err`=1, cc stays {0,1,0}.
